axi_lite_reg_master: RTL and testbench
======================================

// Module: axi_lite_reg_master
// PURPOSE
//  AXI4-Lite initiator: turns one-at-a-time register commands (cmd_*) into AXI4-Lite
//  write/read bursts of length 1 and returns the response on rsp_*. Drives the
//  SPI/peripheral register slaves from an on-chip sequencer or test controller.
//  Exactly one transaction is outstanding at any time.
// PARAMETERS
//  C_M_AXI_DATA_WIDTH  32  data bus width (bits, multiple of 8)
//  C_M_AXI_ADDR_WIDTH  12  address bus width (bits)
// PORTS
//  M_AXI_ACLK     in   1      clock; all logic on rising edge
//  M_AXI_ARESET   in   1      synchronous, active-high reset
//  cmd_valid      in   1      command present
//  cmd_ready      out  1      command accepted when cmd_valid&cmd_ready
//  cmd_wr         in   1      1=write, 0=read
//  cmd_addr       in   AW     byte address
//  cmd_wdata      in   DW     write data
//  cmd_wstrb      in   DW/8   write byte strobes
//  rsp_valid      out  1      response present
//  rsp_ready      in   1      response consumed when rsp_valid&rsp_ready
//  rsp_rdata      out  DW     read data (0 for writes)
//  rsp_resp       out  2      BRESP/RRESP of the transaction
//  M_AXI_AWADDR/AWPROT/AWVALID out AW/3/1, M_AXI_AWREADY in 1
//  M_AXI_WDATA/WSTRB/WVALID out DW/DW/8/1, M_AXI_WREADY in 1
//  M_AXI_BRESP in 2, M_AXI_BVALID in 1, M_AXI_BREADY out 1
//  M_AXI_ARADDR/ARPROT/ARVALID out AW/3/1, M_AXI_ARREADY in 1
//  M_AXI_RDATA in DW, M_AXI_RRESP in 2, M_AXI_RVALID in 1, M_AXI_RREADY out 1
// BEHAVIOUR
//  - Reset: state=IDLE; all *VALID, BREADY, RREADY, rsp_valid = 0; rsp_rdata, rsp_resp,
//    AW/AR/W address/data/strb regs = 0; cmd_ready = 1 the cycle after reset releases.
//  - cmd_ready = (state==IDLE), combinational from state; command fields registered on accept.
//  - AWPROT=ARPROT=3'b000. Addresses passed unmodified (no alignment forced).
//  - FSM: IDLE -> WR_REQ | RD_REQ on accept; all outputs registered.
//    WR_REQ: AWVALID and WVALID rise together the cycle after accept; each drops the
//     cycle after its own handshake (AW and W may complete in either order or same
//     cycle); VALID never withdrawn before handshake. Both done -> WR_RESP.
//    WR_RESP: BREADY=1; on BVALID capture BRESP, rdata=0 -> RSP.
//    RD_REQ: ARVALID=1 until ARREADY -> RD_RESP. RD_RESP: RREADY=1; on RVALID capture
//     RDATA/RRESP -> RSP.
//    RSP: rsp_valid=1, fields stable until rsp_ready; handshake -> IDLE (next cmd accepted
//     one cycle later; no bypass).
//  - Minimum latency, zero-wait slave: write accept->rsp_valid = 3 cycles, read = 3 cycles.
//  - BREADY/RREADY asserted only in the matching RESP state; never both; no stray
//    BVALID/RVALID consumed outside those states.
//  - Non-OKAY responses (SLVERR/DECERR) are passed through, no retry.
//  - Reset mid-transaction: aborts immediately to IDLE with all outputs at reset values.
// CONFIGURATION
//  AXI_REG_MASTER_STATS_EN defined: adds outputs stat_wr_cnt[15:0], stat_rd_cnt[15:0],
//   stat_err_cnt[15:0]; wr/rd increment on each completed B/R handshake, err when
//   resp!=2'b00; wrap 0xFFFF->0; cleared by reset. Undefined: ports and counters absent,
//   all other behaviour identical.
// TESTING
//  - Write addr 0x100 data 0x5A5A0001 strb 0xF, AWREADY=1, WREADY delayed 3 cycles ->
//    one AW handshake, one W handshake, WVALID held 4 cycles, rsp_resp=00, rsp_rdata=0.
//  - Read addr 0x104, ARREADY=1, RVALID 5 cycles after AR with RDATA=0xDEADBEEF ->
//    rsp_rdata=0xDEADBEEF, rsp_resp=00; RREADY low before RD_RESP.
//  - Write with WREADY before AWREADY, BRESP=10 -> rsp_resp=10; STATS: err_cnt=1.
//  - rsp_ready held low 10 cycles -> rsp_valid/rdata stable, cmd_ready=0, no new AXI
//    activity; after handshake cmd_ready=1 next cycle.
//  - Zero-wait slave back-to-back write then read -> each rsp_valid 3 cycles after accept.
//  - Assert M_AXI_ARESET while WVALID high -> next cycle all VALIDs=0, cmd_ready=1 after
//    release; STATS counters=0.

Source files
------------

// File: rtl/axi_lite_reg_master.sv
// AXI4-Lite single-outstanding register initiator: cmd_* in, one AXI write or read out, rsp_* back.
// Optional macro AXI_REG_MASTER_STATS_EN adds completed-write/read/error counters.
module axi_lite_reg_master #(
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_M_AXI_ADDR_WIDTH = 12
) (
    input  logic                              M_AXI_ACLK,
    input  logic                              M_AXI_ARESET,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic                              cmd_wr,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                        rsp_resp,
`ifdef AXI_REG_MASTER_STATS_EN
    output logic [15:0]                       stat_wr_cnt,
    output logic [15:0]                       stat_rd_cnt,
    output logic [15:0]                       stat_err_cnt,
`endif
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [2:0]                        M_AXI_AWPROT,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,
    input  logic [1:0]                        M_AXI_BRESP,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [2:0]                        M_AXI_ARPROT,
    output logic                              M_AXI_ARVALID,
    input  logic                              M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                        M_AXI_RRESP,
    input  logic                              M_AXI_RVALID,
    output logic                              M_AXI_RREADY
);

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_RESP,
        RSP
    } state_t;

    state_t state;

    // A channel whose VALID is already low has finished its handshake.
    logic aw_done;
    logic w_done;

    assign cmd_ready    = (state == IDLE);
    assign M_AXI_AWPROT = 3'b000;
    assign M_AXI_ARPROT = 3'b000;
    assign aw_done      = !M_AXI_AWVALID || M_AXI_AWREADY;
    assign w_done       = !M_AXI_WVALID || M_AXI_WREADY;

    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            state         <= IDLE;
            M_AXI_AWADDR  <= '0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WDATA   <= '0;
            M_AXI_WSTRB   <= '0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_ARADDR  <= '0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_resp      <= 2'b00;
`ifdef AXI_REG_MASTER_STATS_EN
            stat_wr_cnt   <= 16'd0;
            stat_rd_cnt   <= 16'd0;
            stat_err_cnt  <= 16'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_wr) begin
                            M_AXI_AWADDR  <= cmd_addr;
                            M_AXI_WDATA   <= cmd_wdata;
                            M_AXI_WSTRB   <= cmd_wstrb;
                            M_AXI_AWVALID <= 1'b1;
                            M_AXI_WVALID  <= 1'b1;
                            state         <= WR_REQ;
                        end else begin
                            M_AXI_ARADDR  <= cmd_addr;
                            M_AXI_ARVALID <= 1'b1;
                            state         <= RD_REQ;
                        end
                    end
                end
                WR_REQ: begin
                    if (M_AXI_AWVALID && M_AXI_AWREADY) M_AXI_AWVALID <= 1'b0;
                    if (M_AXI_WVALID && M_AXI_WREADY)   M_AXI_WVALID  <= 1'b0;
                    if (aw_done && w_done) begin
                        M_AXI_BREADY <= 1'b1;
                        state        <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (M_AXI_BVALID) begin
                        M_AXI_BREADY <= 1'b0;
                        rsp_resp     <= M_AXI_BRESP;
                        rsp_rdata    <= '0;
                        rsp_valid    <= 1'b1;
                        state        <= RSP;
`ifdef AXI_REG_MASTER_STATS_EN
                        stat_wr_cnt  <= stat_wr_cnt + 16'd1;
                        if (M_AXI_BRESP != 2'b00) stat_err_cnt <= stat_err_cnt + 16'd1;
`endif
                    end
                end
                RD_REQ: begin
                    if (M_AXI_ARREADY) begin
                        M_AXI_ARVALID <= 1'b0;
                        M_AXI_RREADY  <= 1'b1;
                        state         <= RD_RESP;
                    end
                end
                RD_RESP: begin
                    if (M_AXI_RVALID) begin
                        M_AXI_RREADY <= 1'b0;
                        rsp_resp     <= M_AXI_RRESP;
                        rsp_rdata    <= M_AXI_RDATA;
                        rsp_valid    <= 1'b1;
                        state        <= RSP;
`ifdef AXI_REG_MASTER_STATS_EN
                        stat_rd_cnt  <= stat_rd_cnt + 16'd1;
                        if (M_AXI_RRESP != 2'b00) stat_err_cnt <= stat_err_cnt + 16'd1;
`endif
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_reg_master.sv
// Directed bench for axi_lite_reg_master; the AXI slave side is driven by hand from each scenario task.
module tb_axi_lite_reg_master;

    localparam int DW = 32;
    localparam int AW = 12;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            cmd_valid = 1'b0, cmd_ready, cmd_wr = 1'b0;
    logic [AW-1:0]   cmd_addr = '0;
    logic [DW-1:0]   cmd_wdata = '0;
    logic [DW/8-1:0] cmd_wstrb = '0;
    logic            rsp_valid, rsp_ready = 1'b0;
    logic [DW-1:0]   rsp_rdata;
    logic [1:0]      rsp_resp;
    logic [AW-1:0]   awaddr, araddr;
    logic [2:0]      awprot, arprot;
    logic            awvalid, awready = 1'b0;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            wvalid, wready = 1'b0;
    logic [1:0]      bresp = 2'b00;
    logic            bvalid = 1'b0, bready;
    logic            arvalid, arready = 1'b0;
    logic [DW-1:0]   rdata = '0;
    logic [1:0]      rresp = 2'b00;
    logic            rvalid = 1'b0, rready;
`ifdef AXI_REG_MASTER_STATS_EN
    logic [15:0]     stat_wr_cnt, stat_rd_cnt, stat_err_cnt;
`endif

    int total = 0;
    int bad = 0;
    int aw_hs = 0, w_hs = 0, wv_cyc = 0;

    axi_lite_reg_master #(.C_M_AXI_DATA_WIDTH(DW), .C_M_AXI_ADDR_WIDTH(AW)) dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESET(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
`ifdef AXI_REG_MASTER_STATS_EN
        .stat_wr_cnt(stat_wr_cnt), .stat_rd_cnt(stat_rd_cnt), .stat_err_cnt(stat_err_cnt),
`endif
        .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (awvalid && awready) aw_hs <= aw_hs + 1;
        if (wvalid && wready)   w_hs  <= w_hs + 1;
        if (wvalid)             wv_cyc <= wv_cyc + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        total++;
        if ({awvalid, wvalid, arvalid, bready, rready, rsp_valid} !== 6'b0) begin
            bad++; $display("FAIL reset_valids: got %b want 000000", {awvalid, wvalid, arvalid, bready, rready, rsp_valid});
        end
        total++;
        if ({rsp_rdata, rsp_resp} !== 34'h0) begin
            bad++; $display("FAIL reset_rsp: got %h/%b want 0/00", rsp_rdata, rsp_resp);
        end
        total++;
        if ({awaddr, araddr, wdata, wstrb} !== '0) begin
            bad++; $display("FAIL reset_regs: got aw=%h ar=%h wd=%h ws=%h want 0", awaddr, araddr, wdata, wstrb);
        end
        rst = 1'b0;
        tick();
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready);
        end
`ifdef AXI_REG_MASTER_STATS_EN
        total++;
        if ({stat_wr_cnt, stat_rd_cnt, stat_err_cnt} !== 48'h0) begin
            bad++; $display("FAIL reset_stats: got %h %h %h want 0", stat_wr_cnt, stat_rd_cnt, stat_err_cnt);
        end
`endif
    endtask

    task automatic test_write_wready_delay();
        int a0, w0, v0;
        a0 = aw_hs; w0 = w_hs; v0 = wv_cyc;
        awready = 1'b1; wready = 1'b0;
        cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 12'h100; cmd_wdata = 32'h5A5A0001; cmd_wstrb = 4'hF;
        tick();
        cmd_valid = 1'b0;
        total++;
        if ({awvalid, wvalid} !== 2'b11) begin
            bad++; $display("FAIL wr_valids_rise: got %b want 11", {awvalid, wvalid});
        end
        total++;
        if ({awaddr, wdata, wstrb, awprot} !== {12'h100, 32'h5A5A0001, 4'hF, 3'b000}) begin
            bad++; $display("FAIL wr_fields: got %h %h %h %b want 100 5a5a0001 f 000", awaddr, wdata, wstrb, awprot);
        end
        tick();
        total++;
        if ({awvalid, wvalid} !== 2'b01) begin
            bad++; $display("FAIL wr_aw_drop: got %b want 01", {awvalid, wvalid});
        end
        tick();
        tick();
        wready = 1'b1;
        tick();
        wready = 1'b0; awready = 1'b0;
        total++;
        if ({awvalid, wvalid, bready} !== 3'b001) begin
            bad++; $display("FAIL wr_to_resp: got %b want 001", {awvalid, wvalid, bready});
        end
        bvalid = 1'b1; bresp = 2'b00;
        tick();
        bvalid = 1'b0;
        total++;
        if ({rsp_valid, rsp_resp, rsp_rdata, bready} !== {1'b1, 2'b00, 32'h0, 1'b0}) begin
            bad++; $display("FAIL wr_rsp: got v=%b r=%b d=%h br=%b want 1 00 0 0", rsp_valid, rsp_resp, rsp_rdata, bready);
        end
        total++;
        if ({aw_hs - a0, w_hs - w0, wv_cyc - v0} !== {32'd1, 32'd1, 32'd4}) begin
            bad++; $display("FAIL wr_hs_counts: got aw=%0d w=%0d wv=%0d want 1 1 4", aw_hs - a0, w_hs - w0, wv_cyc - v0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        total++;
        if ({rsp_valid, cmd_ready} !== 2'b01) begin
            bad++; $display("FAIL wr_rsp_done: got %b want 01", {rsp_valid, cmd_ready});
        end
    endtask

    task automatic test_read_slow();
        arready = 1'b1;
        cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 12'h104;
        tick();
        cmd_valid = 1'b0;
        total++;
        if ({arvalid, rready, araddr, arprot} !== {1'b1, 1'b0, 12'h104, 3'b000}) begin
            bad++; $display("FAIL rd_req: got v=%b rr=%b a=%h p=%b want 1 0 104 000", arvalid, rready, araddr, arprot);
        end
        tick();
        arready = 1'b0;
        bvalid = 1'b1;
        total++;
        if ({arvalid, rready} !== 2'b01) begin
            bad++; $display("FAIL rd_ar_done: got %b want 01", {arvalid, rready});
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if ({rready, rsp_valid, bready} !== 3'b100) begin
                bad++; $display("FAIL rd_wait%0d: got rr/rv/br=%b want 100", i, {rready, rsp_valid, bready});
            end
        end
        bvalid = 1'b0;
        rvalid = 1'b1; rdata = 32'hDEADBEEF; rresp = 2'b00;
        tick();
        rvalid = 1'b0;
        total++;
        if ({rsp_valid, rsp_rdata, rsp_resp, rready} !== {1'b1, 32'hDEADBEEF, 2'b00, 1'b0}) begin
            bad++; $display("FAIL rd_rsp: got v=%b d=%h r=%b rr=%b want 1 deadbeef 00 0", rsp_valid, rsp_rdata, rsp_resp, rready);
        end
    endtask

    task automatic test_rsp_hold();
        awready = 1'b1; wready = 1'b1; arready = 1'b1;
        cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 12'h300; cmd_wdata = 32'h1; cmd_wstrb = 4'h1;
        for (int i = 0; i < 10; i++) begin
            tick();
            total++;
            if ({rsp_valid, cmd_ready, awvalid, wvalid, arvalid, rsp_rdata} !== {5'b10000, 32'hDEADBEEF}) begin
                bad++; $display("FAIL hold%0d: got v/cr/aw/w/ar=%b d=%h want 10000 deadbeef", i,
                                {rsp_valid, cmd_ready, awvalid, wvalid, arvalid}, rsp_rdata);
            end
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        total++;
        if (cmd_ready !== 1'b0) begin
            bad++; $display("FAIL hold_no_bypass: got cmd_ready=%b want 0", cmd_ready);
        end
        tick();
        rsp_ready = 1'b0;
        awready = 1'b0; wready = 1'b0; arready = 1'b0;
        total++;
        if ({rsp_valid, cmd_ready, awvalid, arvalid} !== 4'b0100) begin
            bad++; $display("FAIL hold_release: got %b want 0100", {rsp_valid, cmd_ready, awvalid, arvalid});
        end
    endtask

    task automatic test_write_w_first_slverr();
        awready = 1'b0; wready = 1'b1;
        cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 12'h200; cmd_wdata = 32'hCAFE0002; cmd_wstrb = 4'h3;
        tick();
        cmd_valid = 1'b0;
        tick();
        total++;
        if ({awvalid, wvalid, bready} !== 3'b100) begin
            bad++; $display("FAIL wf_w_first: got %b want 100", {awvalid, wvalid, bready});
        end
        awready = 1'b1; wready = 1'b0;
        tick();
        awready = 1'b0;
        total++;
        if ({awvalid, wvalid, bready} !== 3'b001) begin
            bad++; $display("FAIL wf_aw_last: got %b want 001", {awvalid, wvalid, bready});
        end
        bvalid = 1'b1; bresp = 2'b10;
        tick();
        bvalid = 1'b0; bresp = 2'b00;
        total++;
        if ({rsp_valid, rsp_resp, rsp_rdata} !== {1'b1, 2'b10, 32'h0}) begin
            bad++; $display("FAIL wf_slverr: got v=%b r=%b d=%h want 1 10 0", rsp_valid, rsp_resp, rsp_rdata);
        end
`ifdef AXI_REG_MASTER_STATS_EN
        total++;
        if ({stat_wr_cnt, stat_rd_cnt, stat_err_cnt} !== {16'd2, 16'd1, 16'd1}) begin
            bad++; $display("FAIL wf_stats: got %0d %0d %0d want 2 1 1", stat_wr_cnt, stat_rd_cnt, stat_err_cnt);
        end
`endif
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int lat;
        awready = 1'b1; wready = 1'b1; arready = 1'b1;
        cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 12'h010; cmd_wdata = 32'h11112222; cmd_wstrb = 4'hF;
        lat = 0;
        for (int n = 1; n <= 10; n++) begin
            tick();
            if (n == 1) cmd_valid = 1'b0;
            if (rsp_valid) begin lat = n; break; end
            bvalid = bready;
        end
        bvalid = 1'b0;
        total++;
        if ({lat, rsp_resp, rsp_rdata} !== {32'd3, 2'b00, 32'h0}) begin
            bad++; $display("FAIL b2b_wr: got lat=%0d r=%b d=%h want 3 00 0", lat, rsp_resp, rsp_rdata);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        total++;
        if ({cmd_ready, rsp_valid} !== 2'b10) begin
            bad++; $display("FAIL b2b_idle: got %b want 10", {cmd_ready, rsp_valid});
        end
        cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 12'h014;
        rdata = 32'h12345678; rresp = 2'b00;
        lat = 0;
        for (int n = 1; n <= 10; n++) begin
            tick();
            if (n == 1) cmd_valid = 1'b0;
            if (rsp_valid) begin lat = n; break; end
            rvalid = rready;
        end
        rvalid = 1'b0;
        total++;
        if ({lat, rsp_resp, rsp_rdata} !== {32'd3, 2'b00, 32'h12345678}) begin
            bad++; $display("FAIL b2b_rd: got lat=%0d r=%b d=%h want 3 00 12345678", lat, rsp_resp, rsp_rdata);
        end
`ifdef AXI_REG_MASTER_STATS_EN
        total++;
        if ({stat_wr_cnt, stat_rd_cnt, stat_err_cnt} !== {16'd3, 16'd2, 16'd1}) begin
            bad++; $display("FAIL b2b_stats: got %0d %0d %0d want 3 2 1", stat_wr_cnt, stat_rd_cnt, stat_err_cnt);
        end
`endif
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        awready = 1'b0; wready = 1'b0; arready = 1'b0;
    endtask

    task automatic test_reset_mid();
        cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 12'h3FC; cmd_wdata = 32'hA5A5A5A5; cmd_wstrb = 4'hC;
        tick();
        cmd_valid = 1'b0;
        total++;
        if (wvalid !== 1'b1) begin
            bad++; $display("FAIL mid_wvalid: got %b want 1", wvalid);
        end
        rst = 1'b1;
        tick();
        total++;
        if ({awvalid, wvalid, arvalid, bready, rready, rsp_valid} !== 6'b0) begin
            bad++; $display("FAIL mid_abort: got %b want 000000", {awvalid, wvalid, arvalid, bready, rready, rsp_valid});
        end
        total++;
        if ({awaddr, wdata, wstrb} !== '0) begin
            bad++; $display("FAIL mid_regs: got %h %h %h want 0", awaddr, wdata, wstrb);
        end
        rst = 1'b0;
        tick();
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++; $display("FAIL mid_cmd_ready: got %b want 1", cmd_ready);
        end
`ifdef AXI_REG_MASTER_STATS_EN
        total++;
        if ({stat_wr_cnt, stat_rd_cnt, stat_err_cnt} !== 48'h0) begin
            bad++; $display("FAIL mid_stats: got %h %h %h want 0", stat_wr_cnt, stat_rd_cnt, stat_err_cnt);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_write_wready_delay();
        test_read_slow();
        test_rsp_hold();
        test_write_w_first_slverr();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
